// File: rtl/eth_decap.sv
// Ethernet RX decapsulation: validates and strips the 16-byte encap header from the
// MAC RX stream and writes payload words into the eth2pcie FIFO write port.
module eth_decap #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter logic        FILTER_EN = 1'b1
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
    output logic [31:0] cnt_frame_ok,
    output logic [31:0] cnt_frame_drop,
    output logic [31:0] cnt_frame_trunc
);

    localparam logic [73:0] TERM_WORD = {1'b1, 1'b1, 8'h00, 64'h0};

    typedef enum logic [1:0] {IDLE, HDR1, PAYLD, DROP} state_t;

    state_t      state_q, state_d;
    logic        stage_vld_q, stage_vld_d;
    logic [73:0] stage_q, stage_d;
    logic        term_pend_q, term_pend_d;
    logic        ovf_q, ovf_d;
    logic [31:0] cnt_ok_q, cnt_ok_d;
    logic [31:0] cnt_drop_q, cnt_drop_d;
    logic [31:0] cnt_trunc_q, cnt_trunc_d;

    logic [47:0] dst_rx;
    logic        dst_ok;
    logic        type_ok;
    logic        lost;
    logic        stage_wr;
    logic        term_wr;

    // Wire order puts byte 0 of the frame in the low bits; MAC_ADDR is written MSB-first.
    always_comb begin
        dst_rx = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            dst_rx[47 - 8*i -: 8] = s_axis_tdata[8*i +: 8];
        end
    end

    assign dst_ok   = !FILTER_EN || (dst_rx == MAC_ADDR) || (dst_rx == '1);
    assign type_ok  = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == ETHERTYPE);
    assign lost     = stage_vld_q & full;
    assign stage_wr = stage_vld_q & ~full;
    assign term_wr  = term_pend_q & ~stage_vld_q & ~full;

    assign wr_en           = stage_wr | term_wr;
    assign din             = term_wr ? TERM_WORD : stage_q;
    assign cnt_frame_ok    = cnt_ok_q;
    assign cnt_frame_drop  = cnt_drop_q;
    assign cnt_frame_trunc = cnt_trunc_q;

    always_comb begin
        state_d     = state_q;
        stage_vld_d = 1'b0;
        stage_d     = stage_q;
        term_pend_d = term_pend_q;
        ovf_d       = ovf_q;
        cnt_ok_d    = cnt_ok_q;
        cnt_drop_d  = cnt_drop_q;
        cnt_trunc_d = cnt_trunc_q;

        if (term_wr) begin
            term_pend_d = 1'b0;
            cnt_trunc_d = cnt_trunc_q + 32'd1;
        end

        // A lost word always leaves the frame needing an error terminator.
        if (lost) begin
            term_pend_d = 1'b1;
            ovf_d       = ~stage_q[72];
        end

        if (stage_wr && stage_q[72]) begin
            if (stage_q[73]) cnt_trunc_d = cnt_trunc_q + 32'd1;
            else             cnt_ok_d    = cnt_ok_q + 32'd1;
        end

        if (s_axis_tvalid) begin
            unique case (state_q)
                IDLE: begin
                    if (s_axis_tlast) begin
                        cnt_drop_d = cnt_drop_q + 32'd1;
                    end else if (dst_ok && !term_pend_q && !lost) begin
                        state_d = HDR1;
                    end else begin
                        state_d = DROP;
                    end
                end
                HDR1: begin
                    if (s_axis_tlast) begin
                        state_d    = IDLE;
                        cnt_drop_d = cnt_drop_q + 32'd1;
                    end else if (type_ok) begin
                        state_d = PAYLD;
                    end else begin
                        state_d = DROP;
                    end
                end
                PAYLD: begin
                    if (ovf_q || lost) begin
                        if (s_axis_tlast) begin
                            state_d = IDLE;
                            ovf_d   = 1'b0;
                        end
                    end else begin
                        stage_vld_d = 1'b1;
                        stage_d     = {s_axis_tlast & ~s_axis_tuser, s_axis_tlast,
                                       s_axis_tkeep, s_axis_tdata};
                        if (s_axis_tlast) state_d = IDLE;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_d    = IDLE;
                        cnt_drop_d = cnt_drop_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            term_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_ok_q    <= '0;
            cnt_drop_q  <= '0;
            cnt_trunc_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_vld_q <= stage_vld_d;
            stage_q     <= stage_d;
            term_pend_q <= term_pend_d;
            ovf_q       <= ovf_d;
            cnt_ok_q    <= cnt_ok_d;
            cnt_drop_q  <= cnt_drop_d;
            cnt_trunc_q <= cnt_trunc_d;
        end
    end

endmodule
